uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_queue.sv | 142 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_default_depth = 16;
    localparam int unsigned c_busy_timeout  = 4;
    localparam int unsigned c_tmo_w         = $clog2(c_busy_timeout) + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = c_default_depth,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~w_full;
    assign w_pop_ok  = i_pop & ~w_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue feeding a serial shifter via a toggle handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = c_default_depth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_toggle,
    input  logic                   tx_done
);

    tx_state_e            r_state;
    tx_state_e            w_next_state;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic                 w_tmo_expired;
    logic                 w_load;
    logic                 w_in_wait_busy;
    logic [7:0]           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           r_tx_data;
    logic                 r_tx_toggle;
    logic                 r_overflow;

    sync_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_wdata (wr_data),
        .i_pop   (w_load),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && tx_done) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A shifter that never reports busy is abandoned, not retried.
                if (!tx_done) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (w_tmo_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_load         = 1'b0;
        w_in_wait_busy = 1'b0;
        case (r_state)
            ST_LOAD:      w_load         = 1'b1;
            ST_WAIT_BUSY: w_in_wait_busy = 1'b1;
            default: begin
                w_load         = 1'b0;
                w_in_wait_busy = 1'b0;
            end
        endcase
    end

    assign w_tmo_expired = (r_tmo_cnt == c_tmo_w'(c_busy_timeout - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait_busy) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // tx_data stays frozen between loads since the shifter reads it all frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data   <= 8'h00;
            r_tx_toggle <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_data   <= w_head;
                r_tx_toggle <= ~r_tx_toggle;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign tx_data   = r_tx_data;
    assign tx_toggle = r_tx_toggle;

endmodule : uart_tx_queue
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Randomized self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic [7:0]    tx_data;
    logic          tx_toggle;
    logic          tx_done = 1'b1;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_toggle (tx_toggle),
        .tx_done   (tx_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: ordered list of accepted bytes, sticky overflow, frame log.
    logic [7:0] m_q [$];
    bit         m_ovf;
    logic       m_last_tog;
    logic [7:0] m_last_data;
    int         cyc;
    int         frames;
    int         tog_cyc [$];

    // Shifter model: 0 = normal, 1 = never goes busy, 2 = held busy.
    int sh_mode;
    bit sh_pending;
    int sh_low;
    int sh_low_min;
    int sh_low_max;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_shifter();
        case (sh_mode)
            1: begin
                tx_done    = 1'b1;
                sh_pending = 1'b0;
                sh_low     = 0;
            end
            2: tx_done = 1'b0;
            default: begin
                if (sh_pending) begin
                    tx_done    = 1'b0;
                    sh_pending = 1'b0;
                    sh_low     = $urandom_range(sh_low_max, sh_low_min);
                end else if (sh_low > 0) begin
                    sh_low--;
                    if (sh_low == 0) tx_done = 1'b1;
                end else begin
                    tx_done = 1'b1;
                end
            end
        endcase
    endtask

    task automatic observe();
        logic [31:0] exp_byte;
        if (tx_toggle !== m_last_tog) begin
            frames++;
            tog_cyc.push_back(cyc);
            m_last_tog = tx_toggle;
            exp_byte   = (m_q.size() > 0) ? 32'(m_q.pop_front()) : 32'h100;
            check_eq("frame_data", 32'(tx_data), exp_byte);
            m_last_data = tx_data;
            if (sh_mode == 0) sh_pending = 1'b1;
        end else begin
            check_eq("tx_data_hold", 32'(tx_data), 32'(m_last_data));
        end
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
        check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) check_eq("busy_nonempty", 32'(busy), 32'd1);
    endtask

    task automatic cycle(input bit we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        if (we) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else                    m_ovf = 1'b1;
        end
        drive_shifter();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        drive_shifter();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst         = 1'b0;
        m_q.delete();
        m_ovf       = 1'b0;
        m_last_tog  = 1'b0;
        m_last_data = 8'h00;
        check_eq("rst_toggle", 32'(tx_toggle), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'h00);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((m_q.size() != 0 || busy) && n < budget) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(m_q.size()), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int p;
        int lat;
        int gap;
        int f0;
        m_ovf = 1'b0; m_last_tog = 1'b0; m_last_data = 8'h00;
        cyc = 0; frames = 0;
        sh_mode = 0; sh_pending = 1'b0; sh_low = 0; sh_low_min = 1; sh_low_max = 1;

        // Single byte: latency and hold until the shifter finishes.
        do_reset();
        tog_cyc.delete();
        cycle(1'b1, 8'hA5);
        p = cyc;
        repeat (3) cycle(1'b0, 8'h00);
        check_eq("single_frames", 32'(tog_cyc.size()), 32'd1);
        lat = (tog_cyc.size() > 0) ? tog_cyc[0] - p : -1;
        check_eq("single_latency", 32'(lat), 32'd2);
        check_eq("single_data", 32'(tx_data), 32'hA5);
        run_until_idle("single", 20);

        // Ordered burst to full, then overflow with a dropped 8'hFF.
        do_reset();
        sh_mode = 2;
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i));
        check_eq("burst_full", 32'(full), 32'd1);
        cycle(1'b1, 8'hFF);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd16);
        sh_mode = 0; sh_low_min = 1; sh_low_max = 3;
        frames = 0;
        run_until_idle("burst", 300);
        check_eq("burst_frames", 32'(frames), 32'd16);
        check_eq("burst_last", 32'(m_last_data), 32'h10);

        // Reset while a frame is in progress with bytes still queued.
        do_reset();
        sh_low_min = 25; sh_low_max = 25;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h40 + i));
        repeat (3) cycle(1'b0, 8'h00);
        check_eq("mid_count", 32'(count), 32'd5);
        do_reset();
        f0 = frames;
        repeat (30) cycle(1'b0, 8'h00);
        check_eq("mid_no_toggle", 32'(frames), 32'(f0));

        // Shifter never reports busy: each byte times out, next one follows.
        do_reset();
        sh_mode = 1;
        tog_cyc.delete();
        cycle(1'b1, 8'h3C);
        p = cyc;
        cycle(1'b1, 8'h5A);
        repeat (14) cycle(1'b0, 8'h00);
        check_eq("tmo_frames", 32'(tog_cyc.size()), 32'd2);
        lat = (tog_cyc.size() > 0) ? tog_cyc[0] - p : -1;
        gap = (tog_cyc.size() > 1) ? tog_cyc[1] - tog_cyc[0] : -1;
        check_eq("tmo_latency", 32'(lat), 32'd2);
        check_eq("tmo_gap", 32'(gap), 32'd6);
        check_eq("tmo_idle", 32'(busy), 32'd0);

        // Random traffic with mixed shifter behaviour and occasional resets.
        sh_mode = 0; sh_low_min = 1; sh_low_max = 6;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) sh_mode = ($urandom_range(3, 0) == 0) ? 1 : 0;
            if ($urandom_range(599, 0) == 0) do_reset();
            else cycle($urandom_range(99, 0) < 45, 8'($urandom));
        end
        sh_mode = 0;
        run_until_idle("random", 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_uart_tx_queue
`default_nettype wire
